// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : 4-requester round-robin arbiter with registered one-hot grant.
//               Define RR_ARB_TIMEOUT_EN to preempt owners after HOLD_MAX
//               cycles while another request is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       gnt_chg
);

  localparam logic [0:0]       C_ST_IDLE   = 1'b0;
  localparam logic [0:0]       C_ST_GRANT  = 1'b1;
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [0:0]       r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_chg;

  logic [0:0]       w_state_nxt;
  logic [3:0]       w_gnt_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             w_win_any;
  logic [1:0]       w_win_idx;
  logic             w_own_req;
  logic             w_issue;

  // Scan from r_ptr upward with wrap; descending loop lets the lowest offset win.
  always_comb begin
    logic [1:0] v_idx;
    w_win_any = 1'b0;
    w_win_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      v_idx = r_ptr + 2'(k);
      if (req[v_idx]) begin
        w_win_any = 1'b1;
        w_win_idx = v_idx;
      end
    end
  end

  assign w_own_req = |(r_gnt & req);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= C_ST_IDLE;
      r_gnt      <= 4'b0000;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
      r_chg      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_chg      <= (w_gnt_nxt != r_gnt);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_issue     = 1'b0;
    case (r_state)
      C_ST_IDLE: begin
        w_issue = en && w_win_any;
      end
      C_ST_GRANT: begin
        if (r_hold_cnt != C_HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + CNT_W'(1);
        end
        if (!w_own_req) begin
          if (en && w_win_any) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = C_ST_IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          // ptr already sits past the owner, so the scan reaches it last.
          if ((r_hold_cnt == C_HOLD_LAST) && en && (|(req & ~r_gnt))) begin
            w_issue = 1'b1;
          end
`else
          w_issue = 1'b0;
`endif
        end
      end
      default: begin
        w_state_nxt = C_ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
    if (w_issue) begin
      w_state_nxt = C_ST_GRANT;
      w_gnt_nxt   = 4'b0001 << w_win_idx;
      w_ptr_nxt   = w_win_idx + 2'd1;
      w_hold_nxt  = '0;
    end
  end

  // Output logic
  always_comb begin
    gnt       = r_gnt;
    gnt_valid = (r_state == C_ST_GRANT);
    gnt_chg   = r_chg;
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed vector table plus corner-case sequences for
//               rr_arbiter_4, with invariant sweep under random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic       chg;
  } vec_t;

  localparam int C_NVEC = 24;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_chg;

  int   n_tests;
  int   n_fail;
  vec_t vecs [C_NVEC];
  int   wait_cnt [4];

  rr_arbiter_4 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_chg   (gnt_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] g, input logic v, input logic c);
    chk({name, ".gnt"}, gnt, g);
    chk({name, ".valid"}, {3'b000, gnt_valid}, {3'b000, v});
    chk({name, ".chg"}, {3'b000, gnt_chg}, {3'b000, c});
  endtask

  task automatic step(input logic e, input logic [3:0] r);
    @(negedge clk);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    req     = 4'b0000;

    // Sequence starts after reset with ptr=0; comments track ptr after each step.
    vecs[0]  = '{1'b1, 4'b0101, 4'b0001, 1'b1, 1'b1}; // ptr 1
    vecs[1]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1}; // handoff, ptr 3
    vecs[2]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 4'b1000, 1'b1, 1'b1}; // ptr 0
    vecs[6]  = '{1'b1, 4'b0111, 4'b0001, 1'b1, 1'b1}; // ptr 1
    vecs[7]  = '{1'b1, 4'b1110, 4'b0010, 1'b1, 1'b1}; // ptr 2
    vecs[8]  = '{1'b1, 4'b1101, 4'b0100, 1'b1, 1'b1}; // ptr 3
    vecs[9]  = '{1'b1, 4'b1011, 4'b1000, 1'b1, 1'b1}; // ptr 0
    vecs[10] = '{1'b1, 4'b0111, 4'b0001, 1'b1, 1'b1}; // ptr 1
    vecs[11] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1}; // no handoff with en=0
    vecs[13] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1}; // ptr 2
    vecs[15] = '{1'b1, 4'b0011, 4'b0010, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1}; // wrap scan, ptr 1
    vecs[17] = '{1'b1, 4'b0011, 4'b0001, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 4'b1110, 4'b0010, 1'b1, 1'b1}; // ptr 2
    vecs[19] = '{1'b1, 4'b0101, 4'b0100, 1'b1, 1'b1}; // 2 beats 0, ptr 3
    vecs[20] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 4'b1001, 4'b1000, 1'b1, 1'b1}; // ptr 0
    vecs[22] = '{1'b1, 4'b1001, 4'b1000, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0};

    #1;
    chk_all("reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < C_NVEC; i++) begin
      step(vecs[i].en, vecs[i].req);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].chg);
    end

    // Asynchronous reset between edges while 1000 is granted.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 1'b0, 1'b0);
    en  = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 4'b0001, 1'b1, 1'b1);

`ifdef RR_ARB_TIMEOUT_EN
    do_reset();
    step(1'b1, 4'b1001);
    chk_all("to_first", 4'b0001, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 4'b1001);
      chk_all($sformatf("to_hold%0d", k), 4'b0001, 1'b1, 1'b0);
    end
    step(1'b1, 4'b1001);
    chk_all("to_preempt", 4'b1000, 1'b1, 1'b1);

    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'b0001);
      chk($sformatf("to_alone%0d", k), gnt, 4'b0001);
    end
    step(1'b1, 4'b1001);
    chk_all("to_sat_preempt", 4'b1000, 1'b1, 1'b1);
`endif

    // Random sweep: one-hot, valid consistency and round-robin fairness.
    do_reset();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      logic [3:0] flip;
      r = req;
      flip = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      r = r ^ flip;
      step($urandom_range(0, 7) != 0, r);
      chk("rnd_onehot", {3'b000, ((gnt & (gnt - 4'd1)) == 4'b0000)}, 4'b0001);
      chk("rnd_valid", {3'b000, gnt_valid}, {3'b000, (gnt != 4'b0000)});
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || gnt[i]) begin
          wait_cnt[i] = 0;
        end else if (gnt_chg && (gnt != 4'b0000)) begin
          wait_cnt[i] = wait_cnt[i] + 1;
        end
      end
      chk("rnd_fair", {3'b000, ((wait_cnt[0] <= 3) && (wait_cnt[1] <= 3) &&
                                (wait_cnt[2] <= 3) && (wait_cnt[3] <= 3))}, 4'b0001);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
